// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared state encoding and phase helpers for the quadrature decoder
package quad_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_00   = 3'd1,
    ST_01   = 3'd2,
    ST_11   = 3'd3,
    ST_10   = 3'd4
  } state_t;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00 on P = {A,B}.
  function automatic logic [1:0] next_fwd(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] next_rev(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic state_t state_of(input logic [1:0] p);
    case (p)
      2'b00:   return ST_00;
      2'b01:   return ST_01;
      2'b11:   return ST_11;
      default: return ST_10;
    endcase
  endfunction

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      ST_01:   return 2'b01;
      ST_11:   return 2'b11;
      ST_10:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Stability counter only ever holds 0 .. filt_cycles-1.
  function automatic int filt_cnt_w(input int filt_cycles);
    return (filt_cycles < 2) ? 1 : $clog2(filt_cycles);
  endfunction

  // INIT timer counts 0 .. filt_cycles+2.
  function automatic int init_cnt_w(input int filt_cycles);
    return $clog2(filt_cycles + 3);
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// rtl/quad_sync_filter.sv - two-flop synchroniser plus stability filter for one encoder phase
module quad_sync_filter #(
  parameter int FILT_CYCLES = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  import quad_pkg::*;

  localparam int CW = filt_cnt_w(FILT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level only after it has differed for FILT_CYCLES cycles.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 != dout) begin
        if (cnt == CNT_LAST) begin
          dout <= s2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature decoder producing up/down step pulses and a wrapping position
module quad_decoder #(
  parameter int W           = 8,
  parameter int FILT_CYCLES = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         enc_a,
  input  logic         enc_b,
  input  logic         clear,
  output logic         up,
  output logic         down,
  output logic [W-1:0] count,
  output logic         dir,
  output logic         err
);
  import quad_pkg::*;

  localparam int TW = init_cnt_w(FILT_CYCLES);
  localparam logic [TW-1:0] INIT_LAST = TW'(FILT_CYCLES + 2);

  logic          filt_a;
  logic          filt_b;
  logic [1:0]    p;
  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;
  logic          step_up;
  logic          step_dn;
  logic          bad;
  logic [1:0]    cur;

  quad_sync_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_a (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (enc_a),
    .dout    (filt_a)
  );

  quad_sync_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_b (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (enc_b),
    .dout    (filt_b)
  );

  assign p = {filt_a, filt_b};

  // State register for the decode FSM.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= state_nx;
  end

  // Next state and step classification from the current state and filtered phase.
  always_comb begin
    state_nx = state;
    step_up  = 1'b0;
    step_dn  = 1'b0;
    bad      = 1'b0;
    cur      = phase_of(state);
    if (state == ST_INIT) begin
      // Adopt whatever level the pins rest at once the filters have settled.
      if (timer == INIT_LAST) state_nx = state_of(p);
    end else if (p != cur) begin
      state_nx = state_of(p);
      if (p == next_fwd(cur))      step_up = 1'b1;
      else if (p == next_rev(cur)) step_dn = 1'b1;
      else                         bad     = 1'b1;
    end
  end

  // INIT hold timer, long enough for the sync chain and filter to reflect the pins.
  always_ff @(posedge clock) begin
    if (!reset_n)                                    timer <= '0;
    else if (state == ST_INIT && timer != INIT_LAST) timer <= timer + TW'(1);
  end

  // Registered pulses, position, direction and sticky error; clear overrides only count and err.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      up    <= 1'b0;
      down  <= 1'b0;
      count <= '0;
      dir   <= 1'b0;
      err   <= 1'b0;
    end else begin
      up   <= step_up;
      down <= step_dn;
      if (step_up || step_dn) dir <= step_up;
      if (clear)        count <= '0;
      else if (step_up) count <= count + 1'b1;
      else if (step_dn) count <= count - 1'b1;
      if (clear)    err <= 1'b0;
      else if (bad) err <= 1'b1;
    end
  end

endmodule
